// File: rtl/btn_pkg.sv
// Shared encodings for the button conditioner: FSM state codes and channel indices.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned BTN_OFF = 0;
    localparam int unsigned BTN_RST = 1;
    localparam int unsigned BTN_PED = 2;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM/counter, pulses and sticky request.
// Long-press counting in HELD is built only when BTN_LONG_PRESS_EN is defined.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH     = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned LONG_CYCLES     = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    input  logic req_clr,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic req,
    output logic long_press
);

    localparam logic [COUNT_WIDTH-1:0] DB_LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Reject parameter sets the counter cannot represent.
    if (DEBOUNCE_CYCLES < 2 || (64'(DEBOUNCE_CYCLES) >> COUNT_WIDTH) != 64'd0) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES out of range");
    end
    if (LONG_CYCLES < 2 || (64'(LONG_CYCLES) >> COUNT_WIDTH) != 64'd0) begin : g_bad_long
        $error("debounce_channel: LONG_CYCLES out of range");
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [COUNT_WIDTH-1:0] LONG_LAST = COUNT_WIDTH'(LONG_CYCLES - 1);
`endif

    logic [1:0]             sync_q;
    logic                   s;
    btn_state_t             state;
    logic [COUNT_WIDTH-1:0] cnt;

    assign s = sync_q[1];

    // Synchronizer idles at 1 so reset looks like a released button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            req           <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            // A live press pulse keeps req set even against a clear.
            req           <= press | (req & ~req_clr);
            case (state)
                IDLE: begin
                    if (!s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                        level <= 1'b1;
                        press <= 1'b1;
                        req   <= 1'b1;
                    end else begin
                        cnt <= cnt + COUNT_WIDTH'(1);
                    end
                end
                HELD: begin
                    if (s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef BTN_LONG_PRESS_EN
                    // Count parks one past LONG_LAST so each hold pulses once.
                    else if (cnt == LONG_LAST) begin
                        long_press <= 1'b1;
                        cnt        <= cnt + COUNT_WIDTH'(1);
                    end else if (cnt < LONG_LAST) begin
                        cnt <= cnt + COUNT_WIDTH'(1);
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (!s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw active-low buttons into debounced levels, pulses and sticky requests.
// The release output is named release_pulse because release is a reserved word. Optional: BTN_LONG_PRESS_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned COUNT_WIDTH     = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter int unsigned LONG_CYCLES     = 12000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    input  logic [N_BTN-1:0] req_clr,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] req,
    output logic [N_BTN-1:0] long_press
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .COUNT_WIDTH    (COUNT_WIDTH),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .btn_n        (btn_n[g]),
            .req_clr      (req_clr[g]),
            .level        (level[g]),
            .press        (press[g]),
            .release_pulse(release_pulse[g]),
            .req          (req[g]),
            .long_press   (long_press[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
// Pulse events are scoreboarded by expected cycle; levels and req are checked inline per scenario.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned LG = 10;
    localparam int unsigned LAT = DB + 3;

    localparam logic [1:0] K_PRESS = 2'd0;
    localparam logic [1:0] K_REL   = 2'd1;
    localparam logic [1:0] K_LONG  = 2'd2;

    typedef struct packed {
        logic [1:0] ch;
        logic [1:0] kind;
        int         cyc;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_n;
    logic [N-1:0] req_clr;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;
    logic [N-1:0] req;
    logic [N-1:0] long_press;

    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    ev_t exp_q[$];

    button_conditioner #(
        .N_BTN          (N),
        .COUNT_WIDTH    (24),
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .req_clr      (req_clr),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .req          (req),
        .long_press   (long_press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input int ch, input logic [1:0] kind, input int at);
        ev_t e;
        e.ch   = 2'(ch);
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Runs every falling edge: pops the scoreboard for each observed pulse.
    task automatic monitor_step();
        ev_t obs;
        ev_t e;
        logic hit;
        compared++;
        if ((press & release_pulse) !== '0) begin
            mismatched++;
            $display("FAIL press_release_overlap cyc=%0d press=%b release=%b required no overlap", cyc, press, release_pulse);
        end
        for (int c = 0; c < int'(N); c++) begin
            for (int k = 0; k < 3; k++) begin
                hit = (k == 0) ? press[c] : (k == 1) ? release_pulse[c] : long_press[c];
                if (hit === 1'b1) begin
                    obs.ch   = 2'(c);
                    obs.kind = 2'(k);
                    obs.cyc  = cyc;
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_event got ch=%0d kind=%0d cyc=%0d, required none", c, k, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (obs !== e) begin
                            mismatched++;
                            $display("FAIL event got ch=%0d kind=%0d cyc=%0d required ch=%0d kind=%0d cyc=%0d",
                                     obs.ch, obs.kind, obs.cyc, e.ch, e.kind, e.cyc);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_n = '1; req_clr = '0;
        tick(3);
        compared++;
        if ({level, press, release_pulse, req, long_press} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got %b required 0", {level, press, release_pulse, req, long_press});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_clean_press();
        int c0 = cyc;
        expect_ev(BTN_PED, K_PRESS, c0 + int'(LAT));
        btn_n[BTN_PED] = 1'b0;
        tick(int'(LAT) - 1);
        compared++;
        if (level[BTN_PED] !== 1'b0) begin
            mismatched++;
            $display("FAIL press_early_level got %b required 0", level[BTN_PED]);
        end
        tick(1);
        compared++;
        if ({level[BTN_PED], req[BTN_PED]} !== 2'b11) begin
            mismatched++;
            $display("FAIL press_level_req got %b required 11", {level[BTN_PED], req[BTN_PED]});
        end
        tick(2);
    endtask

    task automatic test_bounce();
        for (int w = 3; w <= int'(DB); w++) begin
            btn_n[BTN_OFF] = 1'b0;
            tick(w);
            btn_n[BTN_OFF] = 1'b1;
            tick(10);
            compared++;
            if ({level, req} !== {3'b100, 3'b100}) begin
                mismatched++;
                $display("FAIL bounce_w%0d got level=%b req=%b required level=100 req=100", w, level, req);
            end
        end
    endtask

    task automatic test_release();
        int c0 = cyc;
        expect_ev(BTN_PED, K_REL, c0 + int'(LAT));
        btn_n[BTN_PED] = 1'b1;
        tick(int'(LAT) - 1);
        compared++;
        if (level[BTN_PED] !== 1'b1) begin
            mismatched++;
            $display("FAIL release_early_level got %b required 1", level[BTN_PED]);
        end
        tick(1);
        compared++;
        if ({level[BTN_PED], req[BTN_PED]} !== 2'b01) begin
            mismatched++;
            $display("FAIL release_level_req got %b required 01", {level[BTN_PED], req[BTN_PED]});
        end
        tick(2);
    endtask

    task automatic test_req_clr();
        req_clr[BTN_PED] = 1'b1;
        tick(1);
        req_clr[BTN_PED] = 1'b0;
        compared++;
        if (req !== 3'b000) begin
            mismatched++;
            $display("FAIL req_clr got req=%b required 000", req);
        end
        tick(1);
    endtask

    task automatic test_press_clr_collision();
        int c0 = cyc;
        expect_ev(BTN_PED, K_PRESS, c0 + int'(LAT));
        btn_n[BTN_PED] = 1'b0;
        tick(int'(LAT) - 1);
        req_clr[BTN_PED] = 1'b1;
        tick(1);
        compared++;
        if (req[BTN_PED] !== 1'b1) begin
            mismatched++;
            $display("FAIL collision_set got req=%b required 1", req[BTN_PED]);
        end
        tick(1);
        req_clr[BTN_PED] = 1'b0;
        compared++;
        if (req[BTN_PED] !== 1'b1) begin
            mismatched++;
            $display("FAIL collision_hold got req=%b required 1", req[BTN_PED]);
        end
        c0 = cyc;
        expect_ev(BTN_PED, K_REL, c0 + int'(LAT));
        btn_n[BTN_PED] = 1'b1;
        tick(int'(LAT) + 1);
        test_req_clr();
    endtask

    task automatic test_long_press();
        int c0 = cyc;
        expect_ev(BTN_RST, K_PRESS, c0 + int'(LAT));
`ifdef BTN_LONG_PRESS_EN
        expect_ev(BTN_RST, K_LONG, c0 + int'(LAT) + int'(LG));
`endif
        btn_n[BTN_RST] = 1'b0;
        tick(30);
        c0 = cyc;
        expect_ev(BTN_RST, K_REL, c0 + int'(LAT));
        btn_n[BTN_RST] = 1'b1;
        tick(int'(LAT) + 1);
        compared++;
        if ({level[BTN_RST], req[BTN_RST]} !== 2'b01) begin
            mismatched++;
            $display("FAIL long_after_release got %b required 01", {level[BTN_RST], req[BTN_RST]});
        end
        req_clr[BTN_RST] = 1'b1;
        tick(1);
        req_clr[BTN_RST] = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid();
        int c0 = cyc;
        expect_ev(BTN_PED, K_PRESS, c0 + int'(LAT));
        btn_n[BTN_PED] = 1'b0;
        tick(int'(LAT) + 1);
        btn_n[BTN_OFF] = 1'b0;
        tick(5);
        rst = 1'b1;
        #1;
        compared++;
        if ({level, press, release_pulse, req, long_press} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid got %b required 0", {level, press, release_pulse, req, long_press});
        end
        btn_n[BTN_PED] = 1'b1;
        tick(2);
        rst = 1'b0;
        c0 = cyc;
        expect_ev(BTN_OFF, K_PRESS, c0 + int'(LAT));
        tick(int'(LAT) + 1);
        compared++;
        if ({level, req} !== {3'b001, 3'b001}) begin
            mismatched++;
            $display("FAIL reset_mid_repress got level=%b req=%b required 001/001", level, req);
        end
        c0 = cyc;
        expect_ev(BTN_OFF, K_REL, c0 + int'(LAT));
        btn_n[BTN_OFF] = 1'b1;
        tick(int'(LAT) + 1);
        compared++;
        if (level !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_mid_release got level=%b required 000", level);
        end
    endtask

    initial begin
        rst = 1'b1; btn_n = '1; req_clr = '0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_req_clr();
        test_press_clr_collision();
        test_long_press();
        test_reset_mid();
        tick(20);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_events got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
